// File: rtl/fifo_push_arb_pkg.sv
// fifo_push_arb_pkg
//   Shared types and helpers for the fifo_push_arbiter slice.
//   - arb_state_e : arbiter FSM encoding (IDLE, LOCKED)
//   - rr_next     : round-robin pointer increment with wrap at num_req
package fifo_push_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Next round-robin position after ptr, wrapping num_req-1 back to 0.
  function automatic int rr_next(input int ptr, input int num_req);
    return (ptr + 1 >= num_req) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_first_one.sv
// rr_first_one
//   Combinational rotating priority search: returns the first set bit of
//   req_i starting at ptr_i and moving upward modulo NUM_REQ.
// Ports:
//   req_i   in  NUM_REQ  request vector
//   ptr_i   in  IDX_W    position with highest priority
//   idx_o   out IDX_W    index of the winning request (0 when none)
//   found_o out 1        at least one request is set
module rr_first_one #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  // Walk from the lowest-priority position to the highest so that the
  // last hit written is the one closest to ptr_i.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    idx_o    = '0;
    found_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (req_i[cand_idx]) begin
        idx_o   = cand_idx;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
//   Shares the push side of one fifo_v3 between NUM_REQ valid/ready
//   requesters. Round-robin at packet granularity: once a multi-beat packet
//   starts, the grant stays with its owner until the beat with last=1.
//   Every beat is tagged with its source index in the upper fifo data bits.
//   Optional watchdog (define FIFO_PUSH_ARBITER_WATCHDOG_EN) releases a lock
//   after TIMEOUT consecutive stalled cycles and pulses wdog_err_o.
// Ports:
//   clk_i        in  clock
//   rst_ni       in  asynchronous reset, active low
//   flush_i      in  synchronous abort, shared with the fifo flush
//   req_valid_i  in  per-requester beat valid
//   req_data_i   in  per-requester payload, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last_i   in  beat is the final beat of its packet
//   req_ready_o  out beat accepted this cycle (one-hot or zero)
//   fifo_full_i  in  full_o of the downstream fifo
//   fifo_push_o  out push_i of the downstream fifo
//   fifo_data_o  out {source index, payload} to fifo data_i
//   busy_o       out arbiter is locked onto a packet
//   grant_idx_o  out current owner or selected requester
//   wdog_err_o   out (watchdog build only) one-cycle forced-release pulse
module fifo_push_arbiter
  import fifo_push_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int TIMEOUT    = 64,
  localparam int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_push_o,
  output logic [IDX_W+DATA_WIDTH-1:0]   fifo_data_o,
  output logic                          busy_o,
  output logic [IDX_W-1:0]              grant_idx_o
`ifdef FIFO_PUSH_ARBITER_WATCHDOG_EN
 ,output logic                          wdog_err_o
`endif
);

  localparam logic [0:0] ST_IDLE   = 1'(IDLE);
  localparam logic [0:0] ST_LOCKED = 1'(LOCKED);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $fatal(1, "fifo_push_arbiter: NUM_REQ must be in 2..16");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $fatal(1, "fifo_push_arbiter: TIMEOUT must be at least 1");
  end

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] sel, rr_idx;
  logic             rr_found, locked, xfer, sel_last, wdog_hit;

  rr_first_one #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_first_one (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .idx_o   (rr_idx),
    .found_o (rr_found)
  );

  assign locked = (state_q == ST_LOCKED);

  // When idle with nobody valid, rr_idx is already 0, so sel defaults to 0.
  assign sel      = locked ? owner_q : rr_idx;
  assign sel_last = req_last_i[sel];

  // Only the registered full is honoured; a simultaneous pop gives no credit.
  assign xfer = req_valid_i[sel] & ~fifo_full_i & ~flush_i & (locked | rr_found);

  always_comb begin
    req_ready_o      = '0;
    req_ready_o[sel] = xfer;
  end

  assign fifo_push_o = xfer;
  assign fifo_data_o = {sel, req_data_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH]};
  assign busy_o      = locked;
  assign grant_idx_o = sel;

`ifdef FIFO_PUSH_ARBITER_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic             wdog_err_q;

  // The stall that would bring the count to TIMEOUT triggers the release.
  assign wdog_hit = locked & ~xfer & ~flush_i & (wdog_cnt_q == CNT_W'(TIMEOUT - 1));

  // Counter only runs on stalled locked cycles; zero whenever idle, so it is
  // already clear on entry to LOCKED.
  always_comb begin
    wdog_cnt_d = '0;
    if (locked && !xfer && !flush_i && !wdog_hit) wdog_cnt_d = wdog_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_hit;
    end
  end

  assign wdog_err_o = wdog_err_q;
`else
  assign wdog_hit = 1'b0;
`endif

  // Flush dominates; an aborted packet is dropped together with the fifo.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    if (flush_i) begin
      state_d  = ST_IDLE;
      rr_ptr_d = '0;
    end else if (!locked) begin
      if (xfer) begin
        if (sel_last) begin
          rr_ptr_d = IDX_W'(rr_next(int'(sel), NUM_REQ));
        end else begin
          state_d = ST_LOCKED;
          owner_d = sel;
        end
      end
    end else if ((xfer && sel_last) || wdog_hit) begin
      state_d  = ST_IDLE;
      rr_ptr_d = IDX_W'(rr_next(int'(owner_q), NUM_REQ));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

`ifndef SYNTHESIS
  // Requesters hold valid, data and last until accepted (flush excepted).
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_stable
    assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_valid_i[g] && !req_ready_o[g] && !flush_i) |=>
        (req_valid_i[g] && $stable(req_data_i[g*DATA_WIDTH +: DATA_WIDTH]) &&
         $stable(req_last_i[g])));
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) fifo_full_i |-> !fifo_push_o);
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter
//   Directed bench for fifo_push_arbiter (NUM_REQ=4, DATA_WIDTH=32).
//   Inputs change at the falling edge; outputs are sampled 1 time unit later.
//   Payload of requester i is {8'hD0, 6'd0, i, beat number}, where the bench
//   bumps the beat number whenever it expects that requester to be accepted.
//   With FIFO_PUSH_ARBITER_WATCHDOG_EN defined the DUT uses TIMEOUT=8.
module tb_fifo_push_arbiter;

  typedef struct packed {
    logic [3:0] valid;
    logic [3:0] last;
    logic       full;
    logic       flush;
    logic       push;
    logic [3:0] ready;
    logic [1:0] grant;
    logic       busy;
    logic       wdog;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_last;
  logic [3:0]   req_ready;
  logic         fifo_full;
  logic         fifo_push;
  logic [33:0]  fifo_data;
  logic         busy;
  logic [1:0]   grant_idx;
`ifdef FIFO_PUSH_ARBITER_WATCHDOG_EN
  logic         wdog_err;
`endif

  int checks;
  int errors;
  int beat_cnt [4];

  fifo_push_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (32)
`ifdef FIFO_PUSH_ARBITER_WATCHDOG_EN
   ,.TIMEOUT    (8)
`endif
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .fifo_full_i (fifo_full),
    .fifo_push_o (fifo_push),
    .fifo_data_o (fifo_data),
    .busy_o      (busy),
    .grant_idx_o (grant_idx)
`ifdef FIFO_PUSH_ARBITER_WATCHDOG_EN
   ,.wdog_err_o  (wdog_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] last,
                              input logic full, input logic flush_v, input logic push,
                              input logic [3:0] ready, input logic [1:0] grant,
                              input logic busy_v, input logic wdog);
    vec_t v;
    v.valid = valid; v.last = last; v.full = full; v.flush = flush_v;
    v.push = push; v.ready = ready; v.grant = grant; v.busy = busy_v; v.wdog = wdog;
    return v;
  endfunction

  function automatic logic [31:0] data_of(input logic [1:0] i);
    logic [15:0] b;
    b = 16'(beat_cnt[i]);
    return {8'hD0, 6'd0, i, b};
  endfunction

  task automatic drive(input vec_t v);
    req_valid = v.valid;
    req_last  = v.last;
    fifo_full = v.full;
    flush     = v.flush;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = data_of(2'(i));
    #1;
  endtask

  task automatic advance(input vec_t v);
    @(negedge clk);
    for (int i = 0; i < 4; i++) if (v.ready[i]) beat_cnt[i]++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; req_valid = '0; req_last = '0;
    req_data = '0; fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) beat_cnt[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; req_valid = '0; req_last = '0;
    req_data = '0; fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ready got %b want 0000", req_ready); end
    checks++; if (fifo_push !== 1'b0) begin errors++; $display("[TB] FAIL reset_push got %b want 0", fifo_push); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (grant_idx !== 2'd0) begin errors++; $display("[TB] FAIL reset_grant got %0d want 0", grant_idx); end
`ifdef FIFO_PUSH_ARBITER_WATCHDOG_EN
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_wdog got %b want 0", wdog_err); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Requesters 0..2 hold single-beat packets; grants rotate 0,1,2,0,1,2.
  task automatic test_round_robin();
    vec_t tv[$];
    do_reset();
    for (int k = 0; k < 6; k++) begin
      logic [1:0] g;
      g = 2'(k % 3);
      tv.push_back(mk(4'b0111, 4'b1111, 0, 0, 1, 4'b0001 << g, g, 0, 0));
    end
    foreach (tv[k]) begin
      drive(tv[k]);
      checks++;
      if ({fifo_push, req_ready, grant_idx, busy} !== {tv[k].push, tv[k].ready, tv[k].grant, tv[k].busy}) begin
        errors++;
        $display("[TB] FAIL rr_ctl c%0d got push/ready/grant/busy %b/%b/%0d/%b want %b/%b/%0d/%b",
                 k, fifo_push, req_ready, grant_idx, busy, tv[k].push, tv[k].ready, tv[k].grant, tv[k].busy);
      end
      checks++;
      if (fifo_data !== {tv[k].grant, data_of(tv[k].grant)}) begin
        errors++; $display("[TB] FAIL rr_data c%0d got %h want %h", k, fifo_data, {tv[k].grant, data_of(tv[k].grant)});
      end
      advance(tv[k]);
    end
  endtask

  // Req1 sends 4 beats while req0 keeps asking; then req2 wins, then req0.
  task automatic test_multi_beat();
    vec_t tv[$];
    do_reset();
    tv.push_back(mk(4'b0011, 4'b0001, 0, 0, 1, 4'b0001, 2'd0, 0, 0));
    tv.push_back(mk(4'b0011, 4'b0001, 0, 0, 1, 4'b0010, 2'd1, 0, 0));
    tv.push_back(mk(4'b0011, 4'b0001, 0, 0, 1, 4'b0010, 2'd1, 1, 0));
    tv.push_back(mk(4'b0011, 4'b0001, 0, 0, 1, 4'b0010, 2'd1, 1, 0));
    tv.push_back(mk(4'b0011, 4'b0011, 0, 0, 1, 4'b0010, 2'd1, 1, 0));
    tv.push_back(mk(4'b0101, 4'b0101, 0, 0, 1, 4'b0100, 2'd2, 0, 0));
    tv.push_back(mk(4'b0001, 4'b0001, 0, 0, 1, 4'b0001, 2'd0, 0, 0));
    foreach (tv[k]) begin
      drive(tv[k]);
      checks++;
      if ({fifo_push, req_ready, grant_idx, busy} !== {tv[k].push, tv[k].ready, tv[k].grant, tv[k].busy}) begin
        errors++;
        $display("[TB] FAIL lock_ctl c%0d got push/ready/grant/busy %b/%b/%0d/%b want %b/%b/%0d/%b",
                 k, fifo_push, req_ready, grant_idx, busy, tv[k].push, tv[k].ready, tv[k].grant, tv[k].busy);
      end
      checks++;
      if (fifo_data !== {tv[k].grant, data_of(tv[k].grant)}) begin
        errors++; $display("[TB] FAIL lock_data c%0d got %h want %h", k, fifo_data, {tv[k].grant, data_of(tv[k].grant)});
      end
      advance(tv[k]);
    end
  endtask

  // Full while idle: nothing locks, and a newly valid req1 overtakes req2.
  task automatic test_idle_full();
    vec_t tv[$];
    do_reset();
    tv.push_back(mk(4'b0100, 4'b0000, 1, 0, 0, 4'b0000, 2'd2, 0, 0));
    tv.push_back(mk(4'b0110, 4'b0010, 1, 0, 0, 4'b0000, 2'd1, 0, 0));
    tv.push_back(mk(4'b0110, 4'b0010, 0, 0, 1, 4'b0010, 2'd1, 0, 0));
    tv.push_back(mk(4'b0100, 4'b0000, 0, 0, 1, 4'b0100, 2'd2, 0, 0));
    tv.push_back(mk(4'b0100, 4'b0100, 0, 0, 1, 4'b0100, 2'd2, 1, 0));
    foreach (tv[k]) begin
      drive(tv[k]);
      checks++;
      if ({fifo_push, req_ready, grant_idx, busy} !== {tv[k].push, tv[k].ready, tv[k].grant, tv[k].busy}) begin
        errors++;
        $display("[TB] FAIL idle_full_ctl c%0d got push/ready/grant/busy %b/%b/%0d/%b want %b/%b/%0d/%b",
                 k, fifo_push, req_ready, grant_idx, busy, tv[k].push, tv[k].ready, tv[k].grant, tv[k].busy);
      end
      checks++;
      if (fifo_data !== {tv[k].grant, data_of(tv[k].grant)}) begin
        errors++; $display("[TB] FAIL idle_full_data c%0d got %h want %h", k, fifo_data, {tv[k].grant, data_of(tv[k].grant)});
      end
      advance(tv[k]);
    end
  endtask

  // Full for 3 cycles in the middle of req2's 4-beat packet.
  task automatic test_full_mid_packet();
    vec_t tv[$];
    do_reset();
    tv.push_back(mk(4'b0100, 4'b0000, 0, 0, 1, 4'b0100, 2'd2, 0, 0));
    tv.push_back(mk(4'b0100, 4'b0000, 0, 0, 1, 4'b0100, 2'd2, 1, 0));
    for (int k = 0; k < 3; k++)
      tv.push_back(mk(4'b0101, 4'b0001, 1, 0, 0, 4'b0000, 2'd2, 1, 0));
    tv.push_back(mk(4'b0101, 4'b0001, 0, 0, 1, 4'b0100, 2'd2, 1, 0));
    tv.push_back(mk(4'b0101, 4'b0101, 0, 0, 1, 4'b0100, 2'd2, 1, 0));
    tv.push_back(mk(4'b0001, 4'b0001, 0, 0, 1, 4'b0001, 2'd0, 0, 0));
    foreach (tv[k]) begin
      drive(tv[k]);
      checks++;
      if ({fifo_push, req_ready, grant_idx, busy} !== {tv[k].push, tv[k].ready, tv[k].grant, tv[k].busy}) begin
        errors++;
        $display("[TB] FAIL full_ctl c%0d got push/ready/grant/busy %b/%b/%0d/%b want %b/%b/%0d/%b",
                 k, fifo_push, req_ready, grant_idx, busy, tv[k].push, tv[k].ready, tv[k].grant, tv[k].busy);
      end
      checks++;
      if (fifo_data !== {tv[k].grant, data_of(tv[k].grant)}) begin
        errors++; $display("[TB] FAIL full_data c%0d got %h want %h", k, fifo_data, {tv[k].grant, data_of(tv[k].grant)});
      end
      advance(tv[k]);
    end
  endtask

  // Owner req3 drops valid for 5 cycles; the lock must hold.
  task automatic test_bubble();
    vec_t tv[$];
    do_reset();
    tv.push_back(mk(4'b1000, 4'b0000, 0, 0, 1, 4'b1000, 2'd3, 0, 0));
    for (int k = 0; k < 5; k++)
      tv.push_back(mk(4'b0011, 4'b0011, 0, 0, 0, 4'b0000, 2'd3, 1, 0));
    tv.push_back(mk(4'b1011, 4'b1011, 0, 0, 1, 4'b1000, 2'd3, 1, 0));
    tv.push_back(mk(4'b0011, 4'b0011, 0, 0, 1, 4'b0001, 2'd0, 0, 0));
    foreach (tv[k]) begin
      drive(tv[k]);
      checks++;
      if ({fifo_push, req_ready, grant_idx, busy} !== {tv[k].push, tv[k].ready, tv[k].grant, tv[k].busy}) begin
        errors++;
        $display("[TB] FAIL bubble_ctl c%0d got push/ready/grant/busy %b/%b/%0d/%b want %b/%b/%0d/%b",
                 k, fifo_push, req_ready, grant_idx, busy, tv[k].push, tv[k].ready, tv[k].grant, tv[k].busy);
      end
      checks++;
      if (fifo_data !== {tv[k].grant, data_of(tv[k].grant)}) begin
        errors++; $display("[TB] FAIL bubble_data c%0d got %h want %h", k, fifo_data, {tv[k].grant, data_of(tv[k].grant)});
      end
      advance(tv[k]);
    end
  endtask

  // Flush after 2 of 4 beats: back to IDLE with pointer 0, so req0 beats req2.
  task automatic test_flush();
    vec_t tv[$];
    do_reset();
    tv.push_back(mk(4'b0010, 4'b0000, 0, 0, 1, 4'b0010, 2'd1, 0, 0));
    tv.push_back(mk(4'b0011, 4'b0001, 0, 0, 1, 4'b0010, 2'd1, 1, 0));
    tv.push_back(mk(4'b0011, 4'b0001, 0, 1, 0, 4'b0000, 2'd1, 1, 0));
    tv.push_back(mk(4'b0111, 4'b0111, 0, 0, 1, 4'b0001, 2'd0, 0, 0));
    foreach (tv[k]) begin
      drive(tv[k]);
      checks++;
      if ({fifo_push, req_ready, grant_idx, busy} !== {tv[k].push, tv[k].ready, tv[k].grant, tv[k].busy}) begin
        errors++;
        $display("[TB] FAIL flush_ctl c%0d got push/ready/grant/busy %b/%b/%0d/%b want %b/%b/%0d/%b",
                 k, fifo_push, req_ready, grant_idx, busy, tv[k].push, tv[k].ready, tv[k].grant, tv[k].busy);
      end
      checks++;
      if (fifo_data !== {tv[k].grant, data_of(tv[k].grant)}) begin
        errors++; $display("[TB] FAIL flush_data c%0d got %h want %h", k, fifo_data, {tv[k].grant, data_of(tv[k].grant)});
      end
      advance(tv[k]);
    end
  endtask

  // Reset asserted between clock edges while locked must drop busy at once.
  task automatic test_async_reset();
    do_reset();
    drive(mk(4'b0010, 4'b0000, 0, 0, 1, 4'b0010, 2'd1, 0, 0));
    checks++;
    if ({fifo_push, req_ready, grant_idx} !== {1'b1, 4'b0010, 2'd1}) begin
      errors++; $display("[TB] FAIL arst_first got push/ready/grant %b/%b/%0d want 1/0010/1", fifo_push, req_ready, grant_idx);
    end
    advance(mk(4'b0010, 4'b0000, 0, 0, 1, 4'b0010, 2'd1, 0, 0));
    drive(mk(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 2'd1, 1, 0));
    checks++;
    if ({busy, grant_idx} !== {1'b1, 2'd1}) begin
      errors++; $display("[TB] FAIL arst_locked got busy/grant %b/%0d want 1/1", busy, grant_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, grant_idx, fifo_push} !== {1'b0, 2'd0, 1'b0}) begin
      errors++; $display("[TB] FAIL arst_now got busy/grant/push %b/%0d/%b want 0/0/0", busy, grant_idx, fifo_push);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef FIFO_PUSH_ARBITER_WATCHDOG_EN
  // Owner req1 stalls 8 cycles with TIMEOUT=8: forced release, req2 granted.
  task automatic test_watchdog();
    vec_t tv[$];
    do_reset();
    tv.push_back(mk(4'b0010, 4'b0000, 0, 0, 1, 4'b0010, 2'd1, 0, 0));
    for (int k = 0; k < 8; k++)
      tv.push_back(mk(4'b0100, 4'b0100, 0, 0, 0, 4'b0000, 2'd1, 1, 0));
    tv.push_back(mk(4'b0100, 4'b0100, 0, 0, 1, 4'b0100, 2'd2, 0, 1));
    tv.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 0, 0));
    foreach (tv[k]) begin
      drive(tv[k]);
      checks++;
      if ({fifo_push, req_ready, grant_idx, busy} !== {tv[k].push, tv[k].ready, tv[k].grant, tv[k].busy}) begin
        errors++;
        $display("[TB] FAIL wdog_ctl c%0d got push/ready/grant/busy %b/%b/%0d/%b want %b/%b/%0d/%b",
                 k, fifo_push, req_ready, grant_idx, busy, tv[k].push, tv[k].ready, tv[k].grant, tv[k].busy);
      end
      checks++;
      if (wdog_err !== tv[k].wdog) begin
        errors++; $display("[TB] FAIL wdog_err c%0d got %b want %b", k, wdog_err, tv[k].wdog);
      end
      advance(tv[k]);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; flush = 1'b0; req_valid = '0; req_last = '0;
    req_data = '0; fifo_full = 1'b0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_multi_beat();
    test_idle_full();
    test_full_mid_packet();
    test_bubble();
    test_flush();
    test_async_reset();
`ifdef FIFO_PUSH_ARBITER_WATCHDOG_EN
    test_watchdog();
`endif
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
